gpr_scoreboard_file: RTL and testbench

- Parametrised general-purpose register file with configurable width, depth and read-port count.
- Two write ports: port 0 is ALU writeback, port 1 is load/late writeback.
- Per-register busy scoreboard. A register is marked busy when an instruction claims it as destination, and cleared when its writeback lands.
- Sits between decode/issue (claim, operand read) and the execute/memory writeback stages of the pico core.

---
 rtl/gpr_pkg.sv | 23 ++
 rtl/gpr_busy_table.sv | 48 ++++
 rtl/gpr_scoreboard_file.sv | 108 ++++++++++
 tb/tb_gpr_scoreboard_file.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the gpr_scoreboard_file register file.
// Optional feature macro: GPR_BYPASS_EN (write-to-read bypass).
package gpr_pkg;

  localparam int GPR_D_WIDTH     = 8;
  localparam int GPR_A_WIDTH     = 3;
  localparam int GPR_NUM_RD      = 2;

  // Widest register address the helper below accepts; callers zero-extend.
  localparam int GPR_MAX_A_WIDTH = 8;

  // Write-port indices: ALU writeback and load/late writeback.
  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;

  // True when an enabled write port targets addr and that address is not r0.
  function automatic logic addr_hit(input logic [GPR_MAX_A_WIDTH-1:0] addr,
                                    input logic                       en,
                                    input logic [GPR_MAX_A_WIDTH-1:0] wa);
    return en && (wa == addr) && (wa != '0);
  endfunction

endpackage

// File: rtl/gpr_busy_table.sv
// Per-register busy scoreboard: claims set a bit, writebacks clear it,
// a same-cycle claim wins over a clear, and register 0 is never busy.
module gpr_busy_table
  import gpr_pkg::*;
#(
  parameter int A_WIDTH  = GPR_A_WIDTH,
  parameter int REG_DEEP = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  claim_en,
  input  logic [A_WIDTH-1:0]    claim_addr,
  input  logic [1:0]            wr_en,
  input  logic [2*A_WIDTH-1:0]  wr_addr,
  output logic [REG_DEEP-1:0]   busy_vec
);

  logic [A_WIDTH-1:0]  wa_alu;
  logic [A_WIDTH-1:0]  wa_load;
  logic [REG_DEEP-1:0] busy_next;

  assign wa_alu  = wr_addr[WP_ALU*A_WIDTH  +: A_WIDTH];
  assign wa_load = wr_addr[WP_LOAD*A_WIDTH +: A_WIDTH];

  // Next busy bits: set has priority because the new producer supersedes the old one.
  always_comb begin
    busy_next    = busy_vec;
    busy_next[0] = 1'b0;
    for (int r = 1; r < REG_DEEP; r++) begin
      if (addr_hit(GPR_MAX_A_WIDTH'(r), claim_en, GPR_MAX_A_WIDTH'(claim_addr))) begin
        busy_next[r] = 1'b1;
      end else if (addr_hit(GPR_MAX_A_WIDTH'(r), wr_en[WP_ALU],  GPR_MAX_A_WIDTH'(wa_alu)) ||
                   addr_hit(GPR_MAX_A_WIDTH'(r), wr_en[WP_LOAD], GPR_MAX_A_WIDTH'(wa_load))) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  // Busy register; reset drops every pending claim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: rtl/gpr_scoreboard_file.sv
// General-purpose register file with two write ports (ALU, load), a busy
// scoreboard and combinational read ports. Register 0 is hardwired to zero.
// Define GPR_BYPASS_EN to forward same-cycle write data onto the read ports.
module gpr_scoreboard_file
  import gpr_pkg::*;
#(
  parameter int D_WIDTH  = GPR_D_WIDTH,
  parameter int A_WIDTH  = GPR_A_WIDTH,
  parameter int REG_DEEP = 8,
  parameter int NUM_RD   = GPR_NUM_RD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*A_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD*D_WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [1:0]                 wr_en,
  input  logic [2*A_WIDTH-1:0]       wr_addr,
  input  logic [2*D_WIDTH-1:0]       wr_data,
  input  logic                       claim_en,
  input  logic [A_WIDTH-1:0]         claim_addr,
  output logic [REG_DEEP-1:0]        busy_vec,
  output logic                       wr_conflict
);

  logic [D_WIDTH-1:0] regs [REG_DEEP];

  logic [A_WIDTH-1:0] wa_alu;
  logic [A_WIDTH-1:0] wa_load;
  logic [D_WIDTH-1:0] wd_alu;
  logic [D_WIDTH-1:0] wd_load;
  logic               we_alu;
  logic               we_load;

  assign wa_alu  = wr_addr[WP_ALU*A_WIDTH  +: A_WIDTH];
  assign wa_load = wr_addr[WP_LOAD*A_WIDTH +: A_WIDTH];
  assign wd_alu  = wr_data[WP_ALU*D_WIDTH  +: D_WIDTH];
  assign wd_load = wr_data[WP_LOAD*D_WIDTH +: D_WIDTH];

  // Writes to r0 are dropped here, which keeps r0 at its reset value of zero.
  assign we_alu  = wr_en[WP_ALU]  && (wa_alu  != '0);
  assign we_load = wr_en[WP_LOAD] && (wa_load != '0);

  gpr_busy_table #(
    .A_WIDTH  (A_WIDTH),
    .REG_DEEP (REG_DEEP)
  ) u_busy_table (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_vec   (busy_vec)
  );

  // Register storage; the load port is written last so it wins a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_DEEP; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (we_alu) begin
        regs[wa_alu] <= wd_alu;
      end
      if (we_load) begin
        regs[wa_load] <= wd_load;
      end
    end
  end

  // Conflict flag: both ports hit the same non-zero register this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= we_alu && we_load && (wa_alu == wa_load);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [A_WIDTH-1:0] ra;
    logic [D_WIDTH-1:0] data_sel;
    logic               busy_sel;

    assign ra = rd_addr[i*A_WIDTH +: A_WIDTH];

    // Read mux, optionally overridden by a same-cycle write (load port first).
    always_comb begin
      data_sel = regs[ra];
      busy_sel = busy_vec[ra];
`ifdef GPR_BYPASS_EN
      if (addr_hit(GPR_MAX_A_WIDTH'(ra), wr_en[WP_LOAD], GPR_MAX_A_WIDTH'(wa_load))) begin
        data_sel = wd_load;
        busy_sel = 1'b0;
      end else if (addr_hit(GPR_MAX_A_WIDTH'(ra), wr_en[WP_ALU], GPR_MAX_A_WIDTH'(wa_alu))) begin
        data_sel = wd_alu;
        busy_sel = 1'b0;
      end
`endif
    end

    assign rd_data[i*D_WIDTH +: D_WIDTH] = data_sel;
    assign rd_busy[i]                    = busy_sel;
  end

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// Self-checking bench for gpr_scoreboard_file: directed scenarios followed by
// random traffic, checked through an expected-value queue against a
// behavioural model. Follows GPR_BYPASS_EN the same way as the design.
module tb_gpr_scoreboard_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        claim_en = 1'b0;
  logic [2:0]  claim_addr = '0;
  logic [7:0]  busy_vec;
  logic        wr_conflict;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  busy;
    logic [7:0]  bvec;
    logic        conf;
  } exp_t;

  exp_t expQ[$];

  // Reference model: architectural register values, busy bits, conflict flag.
  logic [7:0] mRegs [8];
  logic [7:0] mBusy = '0;
  logic       mConf = 1'b0;

  gpr_scoreboard_file dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .busy_vec    (busy_vec),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    for (int r = 0; r < 8; r++) mRegs[r] = '0;
    mBusy = '0;
    mConf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held during the last cycle.
  task automatic modelStep();
    logic [2:0] a0, a1;
    logic [7:0] nb;
    if (!reset) begin
      modelClear();
    end else begin
      a0 = wr_addr[2:0];
      a1 = wr_addr[5:3];
      nb = mBusy;
      for (int r = 1; r < 8; r++) begin
        if (claim_en && claim_addr == 3'(r)) nb[r] = 1'b1;
        else if ((wr_en[0] && a0 == 3'(r)) || (wr_en[1] && a1 == 3'(r))) nb[r] = 1'b0;
      end
      if (wr_en[0] && a0 != 0) mRegs[a0] = wr_data[7:0];
      if (wr_en[1] && a1 != 0) mRegs[a1] = wr_data[15:8];
      mConf = (wr_en == 2'b11) && (a0 == a1) && (a0 != 0);
      mBusy = nb;
    end
  endtask

  function automatic exp_t computeExpected();
    exp_t e;
    logic [2:0] ra;
    logic [7:0] d;
    logic       b;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      ra = rd_addr[i*3 +: 3];
      d  = mRegs[ra];
      b  = mBusy[ra];
`ifdef GPR_BYPASS_EN
      if (ra != 0 && wr_en[1] && wr_addr[5:3] == ra) begin
        d = wr_data[15:8];
        b = 1'b0;
      end else if (ra != 0 && wr_en[0] && wr_addr[2:0] == ra) begin
        d = wr_data[7:0];
        b = 1'b0;
      end
`endif
      e.data[i*8 +: 8] = d;
      e.busy[i]        = b;
    end
    e.bvec = mBusy;
    e.conf = mConf;
    return e;
  endfunction

  // One cycle of stimulus: advance the model at the edge, drive new inputs, queue expectations.
  task automatic applyStimulus(input logic rst, input logic ce, input logic [2:0] ca,
                               input logic [1:0] we, input logic [2:0] wa0, input logic [7:0] wd0,
                               input logic [2:0] wa1, input logic [7:0] wd1,
                               input logic [2:0] ra0, input logic [2:0] ra1);
    @(posedge clk);
    modelStep();
    #1;
    reset      = rst;
    claim_en   = ce;
    claim_addr = ca;
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    rd_addr    = {ra1, ra0};
    if (!rst) modelClear();
    expQ.push_back(computeExpected());
  endtask

  task automatic idleRead(input logic [2:0] ra0, input logic [2:0] ra1);
    applyStimulus(1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, ra0, ra1);
  endtask

  // Monitor: compare every queued expectation against the DUT away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rd_data",     rd_data,             e.data);
      checkOutput("rd_busy",     16'(rd_busy),        16'(e.busy));
      checkOutput("busy_vec",    16'(busy_vec),       16'(e.bvec));
      checkOutput("wr_conflict", 16'(wr_conflict),    16'(e.conf));
    end
  end

  initial begin
    logic       rst, ce;
    logic [1:0] we;
    modelClear();
    $display("[TB] start");

    // Reset for two cycles, then read all registers back as zero.
    applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 3'd2, 3'd3);
    idleRead(3'd0, 3'd1);
    idleRead(3'd2, 3'd3);
    idleRead(3'd4, 3'd5);
    idleRead(3'd6, 3'd7);
    @(negedge clk);
    checkOutput("reset_busy_vec", 16'(busy_vec), 16'h0000);

    // Claim r3, then write it back through the ALU port.
    applyStimulus(1'b1, 1'b1, 3'd3, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 3'd3, 3'd0);
    idleRead(3'd3, 3'd0);
    @(negedge clk);
    checkOutput("claim_r3_busy_vec", 16'(busy_vec), 16'h0008);
    applyStimulus(1'b1, 1'b0, 3'd0, 2'b01, 3'd3, 8'hA5, 3'd0, 8'h00, 3'd3, 3'd0);
    idleRead(3'd3, 3'd0);
    @(negedge clk);
    checkOutput("wb_r3_busy_vec", 16'(busy_vec), 16'h0000);
    checkOutput("wb_r3_data", 16'(rd_data[7:0]), 16'h00A5);

    // Claim and load-writeback of r5 in the same cycle: claim wins.
    applyStimulus(1'b1, 1'b1, 3'd5, 2'b10, 3'd0, 8'h00, 3'd5, 8'h3C, 3'd0, 3'd0);
    idleRead(3'd5, 3'd0);
    @(negedge clk);
    checkOutput("set_beats_clr_busy5", 16'(busy_vec[5]), 16'h0001);
    checkOutput("set_beats_clr_data5", 16'(rd_data[7:0]), 16'h003C);

    // Both ports write r2: load value wins, conflict pulses for one cycle.
    applyStimulus(1'b1, 1'b0, 3'd0, 2'b11, 3'd2, 8'h11, 3'd2, 8'h22, 3'd0, 3'd0);
    idleRead(3'd2, 3'd0);
    @(negedge clk);
    checkOutput("conflict_data2", 16'(rd_data[7:0]), 16'h0022);
    checkOutput("conflict_pulse", 16'(wr_conflict), 16'h0001);
    idleRead(3'd2, 3'd0);
    @(negedge clk);
    checkOutput("conflict_one_cycle", 16'(wr_conflict), 16'h0000);

    // r0 ignores claims and writes.
    applyStimulus(1'b1, 1'b1, 3'd0, 2'b11, 3'd0, 8'hFF, 3'd0, 8'hFF, 3'd0, 3'd0);
    idleRead(3'd0, 3'd0);
    @(negedge clk);
    checkOutput("r0_busy", 16'(busy_vec[0]), 16'h0000);
    checkOutput("r0_data", rd_data, 16'h0000);
    checkOutput("r0_no_conflict", 16'(wr_conflict), 16'h0000);

    // r6 busy, then written while port 1 reads it in the same cycle.
    applyStimulus(1'b1, 1'b1, 3'd6, 2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 3'd6);
    idleRead(3'd0, 3'd6);
    applyStimulus(1'b1, 1'b0, 3'd0, 2'b01, 3'd6, 8'h7E, 3'd0, 8'h00, 3'd0, 3'd6);
    @(negedge clk);
`ifdef GPR_BYPASS_EN
    checkOutput("bypass_same_data", 16'(rd_data[15:8]), 16'h007E);
    checkOutput("bypass_same_busy", 16'(rd_busy[1]), 16'h0000);
`else
    checkOutput("nobypass_same_data", 16'(rd_data[15:8]), 16'h0000);
    checkOutput("nobypass_same_busy", 16'(rd_busy[1]), 16'h0001);
`endif
    idleRead(3'd0, 3'd6);
    @(negedge clk);
    checkOutput("r6_next_data", 16'(rd_data[15:8]), 16'h007E);
    checkOutput("r6_next_busy", 16'(rd_busy[1]), 16'h0000);

    // Random traffic with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      ce  = $urandom_range(0, 1);
      we  = 2'($urandom_range(0, 3));
      applyStimulus(rst, ce, 3'($urandom_range(0, 7)), we,
                    3'($urandom_range(0, 7)), 8'($urandom),
                    3'($urandom_range(0, 7)), 8'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Drain the queue with a bounded wait.
    idleRead(3'd1, 3'd2);
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    checkOutput("queue_drain", 16'(expQ.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
